reservation_station: RTL

Holds issued instructions for one execution unit until both source operands are available, then dispatches them to the unit. It sits directly downstream of the general-purpose register file: the issue stage reads each operand's `value_valid`/`value`/`rs_id` from the register file read ports and hands them here. The allocated station ID is returned in the same cycle so the issue stage can drive the register file update port. The block snoops the result bus, which also feeds the register file write port, to capture operands that are still in flight.

---
 rtl/reservation_station.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - operand-wait buffer feeding one execution unit
module reservation_station #(
    parameter int DEPTH       = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 1,
    parameter int OP_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    input  logic [OP_WIDTH-1:0]    issue_op,
    input  logic                   issue_a_valid,
    input  logic                   issue_b_valid,
    input  logic [31:0]            issue_a_value,
    input  logic [31:0]            issue_b_value,
    input  logic [RS_ID_WIDTH-1:0] issue_a_rs_id,
    input  logic [RS_ID_WIDTH-1:0] issue_b_rs_id,
    input  logic                   result_valid,
    input  logic [31:0]            result_value,
    input  logic [RS_ID_WIDTH-1:0] result_rs_id,
    output logic                   disp_valid,
    input  logic                   disp_ready,
    output logic [OP_WIDTH-1:0]    disp_op,
    output logic [31:0]            disp_a,
    output logic [31:0]            disp_b,
    output logic [RS_ID_WIDTH-1:0] disp_rs_id
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       a_valid;
    logic [DEPTH-1:0]       b_valid;
    logic [OP_WIDTH-1:0]    op      [DEPTH];
    logic [31:0]            a_value [DEPTH];
    logic [31:0]            b_value [DEPTH];
    logic [RS_ID_WIDTH-1:0] a_tag   [DEPTH];
    logic [RS_ID_WIDTH-1:0] b_tag   [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] snoop_a;
    logic [DEPTH-1:0] snoop_b;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] disp_idx;
    logic             disp_found;
    logic             issue_fire;
    logic             disp_fire;
    logic             in_a_valid;
    logic             in_b_valid;
    logic [31:0]      in_a_value;
    logic [31:0]      in_b_value;

    assign ready       = busy & a_valid & b_valid;
    assign issue_ready = |(~busy);
    assign issue_fire  = issue_valid & issue_ready & ~flush;
    assign disp_valid  = disp_found;
    assign disp_fire   = disp_valid & disp_ready & ~flush;

    // Result landing in the issue cycle would otherwise be missed by both the
    // register file read and the snoop of already-resident entries.
    assign in_a_valid = issue_a_valid | (result_valid & (issue_a_rs_id == result_rs_id));
    assign in_b_valid = issue_b_valid | (result_valid & (issue_b_rs_id == result_rs_id));
    assign in_a_value = issue_a_valid ? issue_a_value : result_value;
    assign in_b_value = issue_b_valid ? issue_b_value : result_value;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign issue_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(alloc_idx);

    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        disp_op    = '0;
        disp_a     = '0;
        disp_b     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
                disp_op    = op[i];
                disp_a     = a_value[i];
                disp_b     = b_value[i];
            end
        end
    end

    assign disp_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(disp_idx);

    always_comb begin
        snoop_a = '0;
        snoop_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            snoop_a[i] = busy[i] & ~a_valid[i] & result_valid & (a_tag[i] == result_rs_id);
            snoop_b[i] = busy[i] & ~b_valid[i] & result_valid & (b_tag[i] == result_rs_id);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= '0;
            a_valid <= '0;
            b_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op[i]      <= '0;
                a_value[i] <= '0;
                b_value[i] <= '0;
                a_tag[i]   <= '0;
                b_tag[i]   <= '0;
            end
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_fire && alloc_idx == IDX_W'(i)) begin
                    busy[i]    <= 1'b1;
                    op[i]      <= issue_op;
                    a_valid[i] <= in_a_valid;
                    a_value[i] <= in_a_value;
                    a_tag[i]   <= issue_a_rs_id;
                    b_valid[i] <= in_b_valid;
                    b_value[i] <= in_b_value;
                    b_tag[i]   <= issue_b_rs_id;
                end else begin
                    if (disp_fire && disp_idx == IDX_W'(i)) begin
                        busy[i] <= 1'b0;
                    end
                    if (snoop_a[i]) begin
                        a_valid[i] <= 1'b1;
                        a_value[i] <= result_value;
                    end
                    if (snoop_b[i]) begin
                        b_valid[i] <= 1'b1;
                        b_value[i] <= result_value;
                    end
                end
            end
        end
    end
endmodule
